// File: rtl/nios_system_cpu_mul_combine_if.sv
// Bundle of the partial-product input channel and the low-product output
// channel for nios_system_cpu_mul_combine.
// Optional macro: NIOS_SYSTEM_CPU_MUL_COMBINE_ZERO_FLAG_EN adds out_zero.
interface nios_system_cpu_mul_combine_if #(
    parameter int TAG_W    = 5,
    parameter int RESULT_W = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_p1;
    logic [31:0]         in_p2;
    logic [31:0]         in_p3;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [RESULT_W-1:0] out_result;
    logic [TAG_W-1:0]    out_tag;
`ifdef NIOS_SYSTEM_CPU_MUL_COMBINE_ZERO_FLAG_EN
    logic                out_zero;

    // Combine block side: consumes partials, produces the low product
    modport slave (
        input  in_valid, in_p1, in_p2, in_p3, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_zero
    );

    // Environment side: multiplier cell upstream, writeback downstream
    modport master (
        output in_valid, in_p1, in_p2, in_p3, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_zero
    );
`else
    // Combine block side: consumes partials, produces the low product
    modport slave (
        input  in_valid, in_p1, in_p2, in_p3, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );

    // Environment side: multiplier cell upstream, writeback downstream
    modport master (
        output in_valid, in_p1, in_p2, in_p3, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );
`endif
endinterface

// File: rtl/nios_system_cpu_mul_combine.sv
// Two-stage valid/ready pipeline that folds the three 16x16 partial products
// (lo*lo, lo*hi, hi*lo) into the low 32 bits of a 32x32 product, carrying the
// destination-register tag alongside. Stage A pre-adds the two cross terms,
// stage B adds the shifted cross sum to lo*lo.
// Optional macro: NIOS_SYSTEM_CPU_MUL_COMBINE_ZERO_FLAG_EN adds a registered
// out_zero flag that travels with the result.
module nios_system_cpu_mul_combine #(
    parameter int TAG_W    = 5,
    parameter int RESULT_W = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    nios_system_cpu_mul_combine_if.slave   mulBus
);

    // Only the 32-bit low product is meaningful for this datapath
    if (RESULT_W != 32) begin : gResultWidthCheck
        $error("nios_system_cpu_mul_combine: RESULT_W must be 32");
    end

    logic             bAdv;
    logic             aAdv;
    logic             inReady;
    logic             inFire;
    logic [31:0]      bSum;

    logic             aValid_q,  aValid_d;
    logic [31:0]      aP1_q,     aP1_d;
    logic [15:0]      aMid_q,    aMid_d;
    logic [TAG_W-1:0] aTag_q,    aTag_d;
    logic             bValid_q,  bValid_d;
    logic [31:0]      bResult_q, bResult_d;
    logic [TAG_W-1:0] bTag_q,    bTag_d;
`ifdef NIOS_SYSTEM_CPU_MUL_COMBINE_ZERO_FLAG_EN
    logic             bZero_q,   bZero_d;
`endif

    // Cross terms only contribute bits 31:16, so stage B adds them shifted up
    assign bSum = aP1_q + {aMid_q, 16'h0000};

    // Stage advance chain: a stage may move when it is empty or its successor moves
    always_comb begin
        bAdv    = !bValid_q || mulBus.out_ready;
        aAdv    = !aValid_q || bAdv;
        inReady = aAdv && !flush;
        inFire  = mulBus.in_valid && inReady;
    end

    // Next-state for both stages; data registers only change when their stage loads
    always_comb begin
        aValid_d  = aValid_q;
        aP1_d     = aP1_q;
        aMid_d    = aMid_q;
        aTag_d    = aTag_q;
        bValid_d  = bValid_q;
        bResult_d = bResult_q;
        bTag_d    = bTag_q;
`ifdef NIOS_SYSTEM_CPU_MUL_COMBINE_ZERO_FLAG_EN
        bZero_d   = bZero_q;
`endif
        if (aAdv) begin
            aValid_d = inFire;
        end
        if (inFire) begin
            aP1_d  = mulBus.in_p1;
            aMid_d = mulBus.in_p2[15:0] + mulBus.in_p3[15:0];
            aTag_d = mulBus.in_tag;
        end
        if (bAdv) begin
            bValid_d = aValid_q;
        end
        if (bAdv && aValid_q) begin
            bResult_d = bSum;
            bTag_d    = aTag_q;
`ifdef NIOS_SYSTEM_CPU_MUL_COMBINE_ZERO_FLAG_EN
            bZero_d   = (bSum == 32'h0000_0000);
`endif
        end
        if (flush) begin
            aValid_d = 1'b0;
            bValid_d = 1'b0;
        end
    end

    // Pipeline registers; reset wins over flush and clears the visible outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            aValid_q  <= 1'b0;
            aP1_q     <= '0;
            aMid_q    <= '0;
            aTag_q    <= '0;
            bValid_q  <= 1'b0;
            bResult_q <= '0;
            bTag_q    <= '0;
`ifdef NIOS_SYSTEM_CPU_MUL_COMBINE_ZERO_FLAG_EN
            bZero_q   <= 1'b0;
`endif
        end else begin
            aValid_q  <= aValid_d;
            aP1_q     <= aP1_d;
            aMid_q    <= aMid_d;
            aTag_q    <= aTag_d;
            bValid_q  <= bValid_d;
            bResult_q <= bResult_d;
            bTag_q    <= bTag_d;
`ifdef NIOS_SYSTEM_CPU_MUL_COMBINE_ZERO_FLAG_EN
            bZero_q   <= bZero_d;
`endif
        end
    end

    assign mulBus.in_ready   = inReady;
    assign mulBus.out_valid  = bValid_q;
    assign mulBus.out_result = bResult_q;
    assign mulBus.out_tag    = bTag_q;
`ifdef NIOS_SYSTEM_CPU_MUL_COMBINE_ZERO_FLAG_EN
    assign mulBus.out_zero   = bZero_q;
`endif

endmodule

// File: tb/tb_nios_system_cpu_mul_combine.sv
// Testbench for nios_system_cpu_mul_combine. Products are predicted from the
// original operands as (src1*src2) mod 2^32 and tracked in an in-order queue.
// Optional macro: NIOS_SYSTEM_CPU_MUL_COMBINE_ZERO_FLAG_EN also checks out_zero.
module tb_nios_system_cpu_mul_combine;

    localparam int TAG_W = 5;

    typedef struct {
        logic [31:0]      result;
        logic [TAG_W-1:0] tag;
    } exp_t;

    typedef struct {
        logic [31:0]      s1;
        logic [31:0]      s2;
        logic [TAG_W-1:0] tag;
        logic [31:0]      expResult;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] curSrc1;
    logic [31:0] curSrc2;
    int          total = 0;
    int          bad   = 0;
    exp_t        expQ[$];
    exp_t        monE;

    always #5 clk = ~clk;

    nios_system_cpu_mul_combine_if #(.TAG_W(TAG_W), .RESULT_W(32)) busIf ();

    nios_system_cpu_mul_combine #(.TAG_W(TAG_W), .RESULT_W(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .mulBus (busIf)
    );

    // Plain-arithmetic reference: full 64-bit product, keep the low word
    function automatic logic [31:0] refProduct(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = 64'(a) * 64'(b);
        return full[31:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, required);
        end
    endtask

    // Drive one multiplier-cell beat, deriving the partials from the operands
    task automatic applyStimulus(input logic valid, input logic [31:0] s1, input logic [31:0] s2,
                                 input logic [TAG_W-1:0] tag);
        curSrc1        = s1;
        curSrc2        = s2;
        busIf.in_valid = valid;
        busIf.in_p1    = 32'(s1[15:0]) * 32'(s2[15:0]);
        busIf.in_p2    = 32'(s1[15:0]) * 32'(s2[31:16]);
        busIf.in_p3    = 32'(s1[31:16]) * 32'(s2[15:0]);
        busIf.in_tag   = tag;
    endtask

    // Scoreboard: compare every output transfer, record every input transfer
    always @(negedge clk) begin
        if (reset) begin
            expQ.delete();
        end else begin
            if (busIf.out_valid && busIf.out_ready) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL mon_unexpected: got result 0x%08h tag %0d, required no output",
                             busIf.out_result, busIf.out_tag);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("mon_result", busIf.out_result, monE.result);
                    checkOutput("mon_tag", 32'(busIf.out_tag), 32'(monE.tag));
`ifdef NIOS_SYSTEM_CPU_MUL_COMBINE_ZERO_FLAG_EN
                    checkOutput("mon_zero", 32'(busIf.out_zero), 32'(monE.result == 32'h0));
`endif
                end
            end
            if (flush) expQ.delete();
            if (busIf.in_valid && busIf.in_ready)
                expQ.push_back('{refProduct(curSrc1, curSrc2), busIf.in_tag});
        end
    end

    // One isolated operation with latency and hold-down checks
    task automatic runSingle(input string name, input logic [31:0] s1, input logic [31:0] s2,
                             input logic [TAG_W-1:0] tag, input logic [31:0] expResult);
        @(posedge clk); #1;
        applyStimulus(1'b1, s1, s2, tag);
        @(negedge clk);
        checkOutput({name, "_in_ready"}, 32'(busIf.in_ready), 32'd1);
        @(posedge clk); #1;
        applyStimulus(1'b0, s1, s2, tag);
        @(negedge clk);
        checkOutput({name, "_lat1_valid"}, 32'(busIf.out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput({name, "_lat2_valid"}, 32'(busIf.out_valid), 32'd1);
        checkOutput({name, "_result"}, busIf.out_result, expResult);
        checkOutput({name, "_tag"}, 32'(busIf.out_tag), 32'(tag));
`ifdef NIOS_SYSTEM_CPU_MUL_COMBINE_ZERO_FLAG_EN
        checkOutput({name, "_zero"}, 32'(busIf.out_zero), 32'(expResult == 32'h0));
`endif
        @(posedge clk);
        @(negedge clk);
        checkOutput({name, "_valid_drop"}, 32'(busIf.out_valid), 32'd0);
    endtask

    // Wait (bounded) for every predicted result to leave the pipeline
    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((expQ.size() != 0 || busIf.out_valid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_drained"}, 32'(expQ.size()), 32'd0);
        checkOutput({name, "_no_timeout"}, 32'(n < 40), 32'd1);
    endtask

    initial begin
        vec_t        vecs[5];
        logic [31:0] bpS1[3];
        logic [31:0] bpS2[3];
        int          opIdx;
        int          validCount;
        int          runLen;
        int          maxRun;
        int          idleValid;

        reset           = 1'b1;
        flush           = 1'b0;
        busIf.out_ready = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, '0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(busIf.out_valid), 32'd0);
        checkOutput("rst_out_result", busIf.out_result, 32'd0);
        checkOutput("rst_out_tag", 32'(busIf.out_tag), 32'd0);
`ifdef NIOS_SYSTEM_CPU_MUL_COMBINE_ZERO_FLAG_EN
        checkOutput("rst_out_zero", 32'(busIf.out_zero), 32'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(busIf.in_ready), 32'd1);

        // Directed vectors including the wrap and zero-result cases
        vecs[0] = '{32'h0001_2345, 32'h0001_0002, 5'd7,  32'h2347_468A};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0001};
        vecs[2] = '{32'h0001_0000, 32'h0001_0000, 5'd12, 32'h0000_0000};
        vecs[3] = '{32'h0000_0003, 32'h0000_0005, 5'd31, 32'h0000_000F};
        vecs[4] = '{32'h8000_0001, 32'h0000_0003, 5'd1,  32'h8000_0003};
        for (int i = 0; i < 5; i++)
            runSingle($sformatf("vec%0d", i), vecs[i].s1, vecs[i].s2, vecs[i].tag, vecs[i].expResult);

        // Eight back-to-back random ops at full throughput
        validCount = 0;
        runLen     = 0;
        maxRun     = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (i < 8) applyStimulus(1'b1, $urandom, $urandom, TAG_W'(i));
            else       applyStimulus(1'b0, 32'h0, 32'h0, '0);
            @(negedge clk);
            if (i < 8) checkOutput($sformatf("b2b_in_ready%0d", i), 32'(busIf.in_ready), 32'd1);
            if (busIf.out_valid) begin
                validCount++;
                runLen++;
                if (runLen > maxRun) maxRun = runLen;
            end else begin
                runLen = 0;
            end
        end
        checkOutput("b2b_valid_count", 32'(validCount), 32'd8);
        checkOutput("b2b_valid_run", 32'(maxRun), 32'd8);
        waitDrain("b2b");

        // Backpressure: three ops offered while the consumer stalls for five cycles
        bpS1[0] = 32'h0000_1111; bpS2[0] = 32'h0000_0002;
        bpS1[1] = 32'h1234_5678; bpS2[1] = 32'h9ABC_DEF0;
        bpS1[2] = 32'hDEAD_BEEF; bpS2[2] = 32'h0000_0010;
        opIdx = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            busIf.out_ready = 1'b0;
            if (opIdx < 3) applyStimulus(1'b1, bpS1[opIdx], bpS2[opIdx], TAG_W'(20 + opIdx));
            else           applyStimulus(1'b0, 32'h0, 32'h0, '0);
            @(negedge clk);
            checkOutput($sformatf("bp_in_ready%0d", c), 32'(busIf.in_ready), 32'(c < 2));
            if (c >= 2) begin
                checkOutput($sformatf("bp_hold_valid%0d", c), 32'(busIf.out_valid), 32'd1);
                checkOutput($sformatf("bp_hold_result%0d", c), busIf.out_result, refProduct(bpS1[0], bpS2[0]));
                checkOutput($sformatf("bp_hold_tag%0d", c), 32'(busIf.out_tag), 32'd20);
            end
            if (busIf.in_ready && busIf.in_valid) opIdx++;
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            busIf.out_ready = 1'b1;
            if (opIdx < 3) applyStimulus(1'b1, bpS1[opIdx], bpS2[opIdx], TAG_W'(20 + opIdx));
            else           applyStimulus(1'b0, 32'h0, 32'h0, '0);
            @(negedge clk);
            if (busIf.in_ready && busIf.in_valid) opIdx++;
        end
        checkOutput("bp_all_accepted", 32'(opIdx), 32'd3);
        waitDrain("bp");

        // Flush with both stages full and a new op offered in the same cycle
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            busIf.out_ready = 1'b0;
            applyStimulus(1'b1, 32'h0000_0100 + c, 32'h0000_0007, TAG_W'(c + 4));
            @(negedge clk);
        end
        @(posedge clk); #1;
        flush = 1'b1;
        applyStimulus(1'b1, 32'h0000_0999, 32'h0000_0003, 5'd9);
        @(negedge clk);
        checkOutput("flush_in_ready", 32'(busIf.in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, '0);
        @(negedge clk);
        checkOutput("flush_out_valid", 32'(busIf.out_valid), 32'd0);
        checkOutput("flush_in_ready_after", 32'(busIf.in_ready), 32'd1);
        busIf.out_ready = 1'b1;
        idleValid = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (busIf.out_valid) idleValid++;
        end
        checkOutput("flush_no_stale", 32'(idleValid), 32'd0);

        // Reset coincident with flush while streaming
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            applyStimulus(1'b1, $urandom, $urandom, TAG_W'(c + 16));
            @(negedge clk);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        flush = 1'b1;
        applyStimulus(1'b1, 32'h0000_0055, 32'h0000_0002, 5'd2);
        @(posedge clk); #1;
        reset = 1'b0;
        flush = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, '0);
        @(negedge clk);
        checkOutput("rstf_out_valid", 32'(busIf.out_valid), 32'd0);
        checkOutput("rstf_out_result", busIf.out_result, 32'd0);
        checkOutput("rstf_out_tag", 32'(busIf.out_tag), 32'd0);
        checkOutput("rstf_in_ready", 32'(busIf.in_ready), 32'd1);
        runSingle("rstf_first", 32'h0000_1234, 32'h0001_0001, 5'd9, 32'h1234_1234);

        // Random traffic with random backpressure and occasional flushes
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            busIf.out_ready = ($urandom_range(0, 9) < 7);
            flush           = ($urandom_range(0, 39) == 0);
            applyStimulus($urandom_range(0, 1) == 1, $urandom, $urandom, TAG_W'($urandom));
        end
        @(posedge clk); #1;
        flush           = 1'b0;
        busIf.out_ready = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, '0);
        waitDrain("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, required finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
